tlb_translation: RTL
====================

TLB_TRANSLATION -- requirements
Module: tlb_translation

Interface
REQ-001 The block SHALL have parameter TLB_ENTRIES, default 8 (power of two, 2..32), giving the number of fully-associative TLB entries.
REQ-002 The block SHALL have parameter ASID_W, default 8, giving the address-space ID width.
REQ-003 The block SHALL have these ports: clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have these ports: reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have these ports: req_valid/req_ready  input/output  1/1  request handshake.
REQ-006 The block SHALL have these ports: req_vaddr  input  32  virtual address.
REQ-007 The block SHALL have these ports: req_write  input  1  store access.
REQ-008 The block SHALL have these ports: kernel_mode  input  1  privilege level, sampled with the request.
REQ-009 The block SHALL have these ports: cur_asid  input  ASID_W  current ASID, sampled with the request.
REQ-010 The block SHALL have these ports: k0_uncached  input  1  kseg0 cacheability select.
REQ-011 The block SHALL have these ports: resp_valid/resp_ready  output/input  1/1  response handshake.
REQ-012 The block SHALL have these ports: resp_paddr  output  32  physical address.
REQ-013 The block SHALL have these ports: resp_uncached  output  1  uncached access.
REQ-014 The block SHALL have these ports: resp_exc  output  3  exception code: 0 none, 1 refill, 2 invalid, 3 modified, 4 address error.
REQ-015 The block SHALL have these ports: tlb_we  input  1  TLB write strobe.
REQ-016 The block SHALL have these ports: tlb_index  input  log2(TLB_ENTRIES)  index of the entry to write.
REQ-017 The block SHALL have these ports: tlb_vpn2  input  19  even/odd page-pair VPN.
REQ-018 The block SHALL have these ports: tlb_asid  input  ASID_W  entry ASID.
REQ-019 The block SHALL have these ports: tlb_g  input  1  global bit.
REQ-020 The block SHALL have these ports: tlb_pfn0/tlb_pfn1  input  20 each  even/odd page frame numbers.
REQ-021 The block SHALL have these ports: tlb_c0/tlb_c1  input  3 each  even/odd cache attributes.
REQ-022 The block SHALL have these ports: tlb_d0/tlb_d1, tlb_v0/tlb_v1  input  1 each  even/odd dirty and valid bits.

Function
REQ-023 The block SHALL be a single registered stage: a request is accepted when req_valid && req_ready, and its result appears on resp_* on the next cycle with resp_valid=1.
REQ-024 req_ready SHALL equal !resp_valid || resp_ready, so one response is held and back-to-back throughput is one per cycle.
REQ-025 resp_* SHALL hold stable while resp_valid && !resp_ready.
REQ-026 resp_valid SHALL clear after a handshake cycle that accepts no new request.
REQ-027 An address error (exc 4, paddr = vaddr, uncached 0) SHALL be reported when !kernel_mode and vaddr[31]=1.
REQ-028 kseg0 (vaddr[31:29]=100) SHALL give paddr = {3'b000, vaddr[28:0]}, uncached = k0_uncached, exc 0.
REQ-029 kseg1 (vaddr[31:29]=101) SHALL give paddr = {3'b000, vaddr[28:0]}, uncached 1, exc 0.
REQ-030 The mapped regions SHALL be useg (vaddr[31]=0) and kseg2/kseg3 (vaddr[31:30]=11), translated with 4 KiB pages.
REQ-031 A TLB entry SHALL hit when entry.vpn2 == vaddr[31:13] and (entry.g || entry.asid == cur_asid); page select is vaddr[12].
REQ-032 When multiple entries hit, the lowest index SHALL win.
REQ-033 A mapped lookup with no hit SHALL report exc 1.
REQ-034 A hit on a page whose v bit is 0 SHALL report exc 2.
REQ-035 A hit with v=1, req_write=1 and d=0 SHALL report exc 3.
REQ-036 Otherwise a hit SHALL give paddr = {pfn, vaddr[11:0]}, uncached = (c == 3'd2), exc 0.
REQ-037 On exc 1, 2 or 3, resp_paddr SHALL be the vaddr and resp_uncached SHALL be 0.
REQ-038 Exception priority SHALL be address error > refill > invalid > modified.
REQ-039 tlb_we SHALL write all fields of entry tlb_index at the clock edge, independently of the request handshake.
REQ-040 A lookup accepted in the same cycle as a write SHALL see the pre-write contents; the next accepted request SHALL see the new contents.
REQ-041 A request held by back-pressure SHALL NOT be re-translated after a TLB write.

Reset
REQ-042 Reset SHALL force resp_valid=0, resp_paddr=0, resp_uncached=0 and resp_exc=0.
REQ-043 Reset SHALL clear every TLB entry (all fields 0, so v0=v1=0 and g=0).
REQ-044 Reset asserted mid-transaction SHALL discard the held response; req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-045 After reset, kernel request vaddr 0x9FC0_0010 with k0_uncached=0 -> next cycle resp_valid=1, paddr 0x1FC0_0010, uncached 0, exc 0; the same request to 0xBFC0_0010 -> paddr 0x1FC0_0010, uncached 1.
REQ-046 After reset, request vaddr 0x0040_0000 -> exc 1; then write index 3 with vpn2 0x00200, asid 5, g 0, pfn0 0x12345, v0 1, d0 0, c0 3, and request with cur_asid 5 -> paddr 0x1234_5000, uncached 0; the same request with cur_asid 6 -> exc 1.
REQ-047 Store to the page from REQ-046 -> exc 3; request vaddr 0x0040_1000 (odd page, v1=0) -> exc 2; user-mode request vaddr 0x8000_0000 -> exc 4.
REQ-048 Hold resp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and resp_* stable throughout; after release, the queued request is accepted and its response follows on the next cycle.
REQ-049 tlb_we and an accepted request to the same VPN in one cycle -> that response uses the old entry, the following request uses the new one; a duplicate hit on indices 1 and 4 -> index 1's pfn.
REQ-050 Assert reset while resp_valid=1 and resp_ready=0 -> resp_valid=0 and all entries invalid afterwards, so a mapped lookup returns exc 1.

Source files
------------

// File: rtl/tlb_translation.sv
// Single-stage MIPS-style virtual-to-physical translation with a fully-associative,
// software-loaded TLB of even/odd page pairs and fixed kseg0/kseg1 windows.
module tlb_translation #(
  parameter int TLB_ENTRIES = 8,
  parameter int ASID_W      = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_vaddr,
  input  logic                           req_write,
  input  logic                           kernel_mode,
  input  logic [ASID_W-1:0]              cur_asid,
  input  logic                           k0_uncached,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [31:0]                    resp_paddr,
  output logic                           resp_uncached,
  output logic [2:0]                     resp_exc,
  input  logic                           tlb_we,
  input  logic [$clog2(TLB_ENTRIES)-1:0] tlb_index,
  input  logic [18:0]                    tlb_vpn2,
  input  logic [ASID_W-1:0]              tlb_asid,
  input  logic                           tlb_g,
  input  logic [19:0]                    tlb_pfn0,
  input  logic [19:0]                    tlb_pfn1,
  input  logic [2:0]                     tlb_c0,
  input  logic [2:0]                     tlb_c1,
  input  logic                           tlb_d0,
  input  logic                           tlb_d1,
  input  logic                           tlb_v0,
  input  logic                           tlb_v1
);

  localparam logic [2:0] EXC_NONE    = 3'd0;
  localparam logic [2:0] EXC_REFILL  = 3'd1;
  localparam logic [2:0] EXC_INVALID = 3'd2;
  localparam logic [2:0] EXC_MOD     = 3'd3;
  localparam logic [2:0] EXC_ADDR    = 3'd4;

  logic [18:0]       e_vpn2 [TLB_ENTRIES];
  logic [ASID_W-1:0] e_asid [TLB_ENTRIES];
  logic              e_g    [TLB_ENTRIES];
  logic [19:0]       e_pfn0 [TLB_ENTRIES];
  logic [19:0]       e_pfn1 [TLB_ENTRIES];
  logic [2:0]        e_c0   [TLB_ENTRIES];
  logic [2:0]        e_c1   [TLB_ENTRIES];
  logic              e_d0   [TLB_ENTRIES];
  logic              e_d1   [TLB_ENTRIES];
  logic              e_v0   [TLB_ENTRIES];
  logic              e_v1   [TLB_ENTRIES];

  logic        hit, h_d, h_v;
  logic [19:0] h_pfn;
  logic [2:0]  h_c;
  logic [31:0] x_paddr;
  logic        x_unc;
  logic [2:0]  x_exc;
  logic        accept;

  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit   = 1'b0;
    h_pfn = '0;
    h_c   = '0;
    h_d   = 1'b0;
    h_v   = 1'b0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (e_vpn2[i] == req_vaddr[31:13] && (e_g[i] || e_asid[i] == cur_asid)) begin
        hit   = 1'b1;
        h_pfn = req_vaddr[12] ? e_pfn1[i] : e_pfn0[i];
        h_c   = req_vaddr[12] ? e_c1[i]   : e_c0[i];
        h_d   = req_vaddr[12] ? e_d1[i]   : e_d0[i];
        h_v   = req_vaddr[12] ? e_v1[i]   : e_v0[i];
      end
    end
  end

  always_comb begin
    x_paddr = req_vaddr;
    x_unc   = 1'b0;
    x_exc   = EXC_NONE;
    if (!kernel_mode && req_vaddr[31]) begin
      x_exc = EXC_ADDR;
    end else if (req_vaddr[31:30] == 2'b10) begin
      x_paddr = {3'b000, req_vaddr[28:0]};
      x_unc   = req_vaddr[29] | k0_uncached;
    end else if (!hit) begin
      x_exc = EXC_REFILL;
    end else if (!h_v) begin
      x_exc = EXC_INVALID;
    end else if (req_write && !h_d) begin
      x_exc = EXC_MOD;
    end else begin
      x_paddr = {h_pfn, req_vaddr[11:0]};
      x_unc   = (h_c == 3'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid    <= 1'b0;
      resp_paddr    <= '0;
      resp_uncached <= 1'b0;
      resp_exc      <= EXC_NONE;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        e_vpn2[i] <= '0;
        e_asid[i] <= '0;
        e_g[i]    <= 1'b0;
        e_pfn0[i] <= '0;
        e_pfn1[i] <= '0;
        e_c0[i]   <= '0;
        e_c1[i]   <= '0;
        e_d0[i]   <= 1'b0;
        e_d1[i]   <= 1'b0;
        e_v0[i]   <= 1'b0;
        e_v1[i]   <= 1'b0;
      end
    end else begin
      // The lookup above reads the pre-edge table, so a same-cycle write is seen only by later requests.
      if (tlb_we) begin
        e_vpn2[tlb_index] <= tlb_vpn2;
        e_asid[tlb_index] <= tlb_asid;
        e_g[tlb_index]    <= tlb_g;
        e_pfn0[tlb_index] <= tlb_pfn0;
        e_pfn1[tlb_index] <= tlb_pfn1;
        e_c0[tlb_index]   <= tlb_c0;
        e_c1[tlb_index]   <= tlb_c1;
        e_d0[tlb_index]   <= tlb_d0;
        e_d1[tlb_index]   <= tlb_d1;
        e_v0[tlb_index]   <= tlb_v0;
        e_v1[tlb_index]   <= tlb_v1;
      end
      if (accept) begin
        resp_valid    <= 1'b1;
        resp_paddr    <= x_paddr;
        resp_uncached <= x_unc;
        resp_exc      <= x_exc;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule
